instr_encoder: RTL
==================

# instr_encoder

Streaming RV32I instruction encoder: the inverse of the core's decode path. Accepts symbolic requests (kind, function code, register indices, immediate) over a valid/ready handshake and packs them into 32-bit instruction words. Writes the words to consecutive addresses of an instruction-memory write port. Used by the self-test loader and testbenches to build programs in imem without an external toolchain.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 8: imem word-address width; write pointer wraps at 2^ADDR_WIDTH.
- `BASE_ADDR`, default 0: pointer value after reset.

**Ports**
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on edge when `req_valid && req_ready`.
- `req_kind` in 2: `req_kind_t`; 0 OP, 1 OP_IMM, 2 BRANCH, 3 reserved (illegal).
- `req_funct` in 10: OP uses all 10 bits as `op_funct7_func3_t`. OP_IMM uses [2:0] as `op_imm_func3_t`; bit [3]=1 selects SRAI when func3 is SRLI_SRAI. BRANCH uses [2:0] as `branch_func3_t`.
- `req_rd`, `req_rs1`, `req_rs2` in 5 each: register indices; unused fields are ignored.
- `req_imm` in 13: signed immediate.
- `mem_we` out 1: write strobe; equals the output-register valid.
- `mem_addr` out ADDR_WIDTH: write word address.
- `mem_wdata` out 32: encoded instruction.
- `mem_ready` in 1: memory accepts the write on edge when `mem_we && mem_ready`.
- `err` out 1: sticky illegal-request flag.
- `count` out ADDR_WIDTH+1: number of words written since reset; saturates at all-ones.

## Operation
- Encode on accept, register into a one-entry output stage (`out_valid`, word).
- `req_ready = !out_valid || mem_ready`. Gives full throughput with no combinational path from `req_valid` to `req_ready`.
- **OP:** {funct[9:3], rs2, rs1, funct[2:0], rd, 0110011}. Funct not in the enum is illegal.
- **OP_IMM, non-shift:** {imm[11:0], rs1, f3, rd, 0010011}. Legal range is −2048..2047.
- **OP_IMM, shift (SLLI, SRLI_SRAI):** imm must be 0..31. Bits [31:25] are 0100000 for SRAI, otherwise 0. Bit [3]=1 with SLLI is illegal.
- **BRANCH:** {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 1100011}. Illegal if imm[0]=1 or func3 is 010 or 011.
- **Illegal request:** handshake completes normally, no word is emitted, `err` is set. `err` stays set until `rst`.
- **Write pointer:** increments by one per completed write. Wraps from 2^ADDR_WIDTH−1 to 0 silently; `count` keeps counting.
- **Reset values:** `mem_we`=0, `mem_addr`=BASE_ADDR, `mem_wdata`=0, `err`=0, `count`=0, `req_ready`=1.

## Timing
- Latency: request accepted at edge N → `mem_we`=1 with the word during cycle N+1.
- Throughput: one word per cycle while `mem_ready`=1.
- Backpressure: while `mem_we && !mem_ready`, the word and `mem_addr` hold stable and `req_ready`=0.
- Simultaneous drain and accept: the output register reloads on the same edge, so there is no bubble.
- An illegal request arriving while the output drains leaves `out_valid`=0 on the next cycle.
- `rst` mid-transfer: the pending word is discarded and all state returns to reset values on that edge. Inputs are ignored in the reset cycle.

## Structure
- Add `req_kind_t` and opcode constants (`OPC_OP`=0110011, `OPC_OP_IMM`=0010011, `OPC_BRANCH`=1100011) to the shared `function_codes` package alongside the existing function-code enums.
- One combinational sub-module, `instr_field_pack`: request fields → {word, illegal}. The top level holds the handshake, output register, pointer, `count` and `err`.

## Test plan
- ADD x3,x1,x2 then SUB x5,x6,x7 back-to-back, `mem_ready`=1 → 0x002081B3 @0, 0x407302B3 @1 on consecutive cycles; `count`=2.
- ADDI x1,x0,−1; SRAI x2,x2,3; BEQ x1,x2,−4 → 0xFFF00093, 0x40315113, 0xFE208EE3.
- `mem_ready`=0 for 3 cycles with a word pending → `mem_we`, address and data stable; `req_ready`=0; no second word lost.
- Illegal requests (kind 3; ADDI imm 2048; BEQ imm 3; SLLI imm 32) → no writes, `err`=1 after the first, pointer unchanged. The next legal request writes at the same address.
- ADDR_WIDTH=2, 5 writes → addresses 0,1,2,3,0; `count`=5.
- Assert `rst` while `mem_we`=1 and `mem_ready`=0 → next cycle `mem_we`=0, `mem_addr`=BASE_ADDR, `err`=0, `count`=0.

Source files
------------

// File: rtl/function_codes.sv
// -----------------------------------------------------------------------------
// function_codes
//   Shared RV32I encoding vocabulary for the decode and encode paths.
//   - req_kind_t          : request class accepted by the instruction encoder
//   - op_funct7_func3_t   : {funct7, funct3} of the register-register ALU ops
//   - op_imm_func3_t      : funct3 of the register-immediate ALU ops
//   - branch_func3_t      : funct3 of the conditional branches
//   - OPC_* constants     : 7-bit major opcodes
//   - helper functions    : legality checks used by the field packer
// -----------------------------------------------------------------------------
package function_codes;

  // Request class. KIND_RSVD is never legal; it exists so the full 2-bit
  // space has a name.
  typedef enum logic [1:0] {
    KIND_OP     = 2'd0,
    KIND_OP_IMM = 2'd1,
    KIND_BRANCH = 2'd2,
    KIND_RSVD   = 2'd3
  } req_kind_t;

  // Register-register ops, encoded as {funct7, funct3}.
  typedef enum logic [9:0] {
    OP_ADD  = 10'h000,
    OP_SLL  = 10'h001,
    OP_SLT  = 10'h002,
    OP_SLTU = 10'h003,
    OP_XOR  = 10'h004,
    OP_SRL  = 10'h005,
    OP_OR   = 10'h006,
    OP_AND  = 10'h007,
    OP_SUB  = 10'h100,
    OP_SRA  = 10'h105
  } op_funct7_func3_t;

  // Register-immediate ops. SRLI and SRAI share funct3; the request picks
  // between them with a separate select bit.
  typedef enum logic [2:0] {
    IMM_ADDI      = 3'b000,
    IMM_SLLI      = 3'b001,
    IMM_SLTI      = 3'b010,
    IMM_SLTIU     = 3'b011,
    IMM_XORI      = 3'b100,
    IMM_SRLI_SRAI = 3'b101,
    IMM_ORI       = 3'b110,
    IMM_ANDI      = 3'b111
  } op_imm_func3_t;

  // Conditional branches. 3'b010 and 3'b011 are unassigned.
  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_func3_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Upper seven bits of a shift-immediate word.
  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  // Position of the SRAI select bit inside req_funct.
  localparam int unsigned SRA_SEL_BIT = 32'd3;

  // True when the 13-bit signed value fits a 12-bit signed field
  // (-2048..2047): the top two bits must agree.
  function automatic logic fits_simm12(input logic [12:0] imm);
    fits_simm12 = (imm[12] == imm[11]);
  endfunction

  // True when the 13-bit value is a legal shift amount (0..31).
  function automatic logic fits_uimm5(input logic [12:0] imm);
    fits_uimm5 = (imm[12:5] == 8'd0);
  endfunction

  // True for every {funct7, funct3} pair listed in op_funct7_func3_t.
  function automatic logic op_funct_legal(input logic [9:0] funct);
    case (funct)
      OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
      OP_SRL, OP_OR, OP_AND, OP_SUB, OP_SRA: op_funct_legal = 1'b1;
      default:                               op_funct_legal = 1'b0;
    endcase
  endfunction

  // True for every assigned branch funct3.
  function automatic logic branch_f3_legal(input logic [2:0] f3);
    case (f3)
      BR_BEQ, BR_BNE, BR_BLT,
      BR_BGE, BR_BLTU, BR_BGEU: branch_f3_legal = 1'b1;
      default:                  branch_f3_legal = 1'b0;
    endcase
  endfunction

  // True for the two funct3 codes that take a shift amount instead of
  // a full immediate.
  function automatic logic is_shift_f3(input logic [2:0] f3);
    case (f3)
      IMM_SLLI, IMM_SRLI_SRAI: is_shift_f3 = 1'b1;
      default:                 is_shift_f3 = 1'b0;
    endcase
  endfunction

endpackage : function_codes

// File: rtl/instr_field_pack.sv
// -----------------------------------------------------------------------------
// instr_field_pack
//   Purely combinational: turns one symbolic request into a 32-bit RV32I
//   word and flags requests that have no legal encoding.
//
//   kind_i    in  2   request class (req_kind_t)
//   funct_i   in  10  function code; meaning depends on kind_i
//   rd_i      in  5   destination register
//   rs1_i     in  5   first source register
//   rs2_i     in  5   second source register
//   imm_i     in  13  signed immediate
//   word_o    out 32  packed instruction (don't-care when illegal_o)
//   illegal_o out 1   request cannot be encoded
// -----------------------------------------------------------------------------
module instr_field_pack
  import function_codes::*;
(
  input  req_kind_t   kind_i,
  input  logic [9:0]  funct_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [12:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  logic [2:0] f3;
  logic       sra_sel;
  logic [6:0] shift_f7;

  assign f3       = funct_i[2:0];
  assign sra_sel  = funct_i[SRA_SEL_BIT];
  // The select bit only means SRAI under the SRLI_SRAI funct3.
  assign shift_f7 = ((f3 == IMM_SRLI_SRAI) && sra_sel) ? FUNCT7_ALT : FUNCT7_BASE;

  // Field packing and legality for each request class.
  always_comb begin
    word_o    = 32'd0;
    illegal_o = 1'b0;
    case (kind_i)
      KIND_OP: begin
        word_o    = {funct_i[9:3], rs2_i, rs1_i, funct_i[2:0], rd_i, OPC_OP};
        illegal_o = !op_funct_legal(funct_i);
      end
      KIND_OP_IMM: begin
        if (is_shift_f3(f3)) begin
          // Shift amount sits where rs2 would be; the SRAI marker rides in
          // the upper seven bits.
          word_o    = {shift_f7, imm_i[4:0], rs1_i, f3, rd_i, OPC_OP_IMM};
          illegal_o = !fits_uimm5(imm_i) || ((f3 == IMM_SLLI) && sra_sel);
        end else begin
          word_o    = {imm_i[11:0], rs1_i, f3, rd_i, OPC_OP_IMM};
          illegal_o = !fits_simm12(imm_i);
        end
      end
      KIND_BRANCH: begin
        // B-type scatters the even offset; bit 0 has no slot so it must be 0.
        word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3,
                     imm_i[4:1], imm_i[11], OPC_BRANCH};
        illegal_o = !branch_f3_legal(f3) || imm_i[0];
      end
      KIND_RSVD: begin
        illegal_o = 1'b1;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule : instr_field_pack

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Streaming RV32I encoder. Accepts symbolic requests over valid/ready,
//   packs them into instruction words and writes them to consecutive
//   addresses of an instruction-memory write port.
//
//   Parameters
//     ADDR_WIDTH  imem word-address width; pointer wraps at 2**ADDR_WIDTH
//     BASE_ADDR   pointer value after reset
//
//   Ports
//     clk, rst              clock, synchronous active-high reset
//     req_valid/req_ready   request handshake
//     req_kind, req_funct   request class and function code
//     req_rd/rs1/rs2        register indices
//     req_imm               13-bit signed immediate
//     mem_we/addr/wdata     imem write port (mem_we = output stage valid)
//     mem_ready             imem accepts the write this edge
//     err                   sticky illegal-request flag
//     count                 words written since reset, saturating
// -----------------------------------------------------------------------------
module instr_encoder
  import function_codes::*;
#(
  parameter int unsigned ADDR_WIDTH = 32'd8,
  parameter int unsigned BASE_ADDR  = 32'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  req_kind_t             req_kind,
  input  logic [9:0]            req_funct,
  input  logic [4:0]            req_rd,
  input  logic [4:0]            req_rs1,
  input  logic [4:0]            req_rs2,
  input  logic [12:0]           req_imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH-1:0] PTR_RESET = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(32'd1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(32'd1);
  localparam logic [ADDR_WIDTH:0]   CNT_MAX   = '1;

  logic                  out_valid_q, out_valid_d;
  logic [31:0]           word_q,      word_d;
  logic [ADDR_WIDTH-1:0] ptr_q,       ptr_d;
  logic [ADDR_WIDTH:0]   count_q,     count_d;
  logic                  err_q,       err_d;

  logic        accept;
  logic        drain;
  logic [31:0] pack_word;
  logic        pack_illegal;

  instr_field_pack u_pack (
    .kind_i    (req_kind),
    .funct_i   (req_funct),
    .rd_i      (req_rd),
    .rs1_i     (req_rs1),
    .rs2_i     (req_rs2),
    .imm_i     (req_imm),
    .word_o    (pack_word),
    .illegal_o (pack_illegal)
  );

  // Ready depends only on the output stage and the memory, never on
  // req_valid, so a drain and a new accept can share one edge.
  assign req_ready = !out_valid_q || mem_ready;
  assign accept    = req_valid && req_ready;
  assign drain     = out_valid_q && mem_ready;

  // Next state: drain first, then a possible reload on the same edge.
  always_comb begin
    out_valid_d = out_valid_q;
    word_d      = word_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    err_d       = err_q;

    if (drain) begin
      out_valid_d = 1'b0;
      ptr_d       = ptr_q + PTR_ONE;
      if (count_q != CNT_MAX) begin
        count_d = count_q + CNT_ONE;
      end else begin
        count_d = count_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end

    // An accept implies the stage is empty or draining now, so an illegal
    // request leaves it empty without needing an explicit clear here.
    if (accept) begin
      if (pack_illegal) begin
        err_d = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        word_d      = pack_word;
      end
    end else begin
      err_d = err_q;
    end
  end

  // State registers with synchronous reset; inputs are ignored while rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      word_q      <= 32'd0;
      ptr_q       <= PTR_RESET;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      word_q      <= word_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = out_valid_q;
  assign mem_addr  = ptr_q;
  assign mem_wdata = word_q;
  assign err       = err_q;
  assign count     = count_q;

endmodule : instr_encoder
